// File: rtl/arm_pipe_pkg.sv
// Shared encodings for the ARM pipeline sequencer.
package arm_pipe_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_inc && (r_q != '1)) begin
            r_q <= r_q + 1'b1;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline sequencer: merges hazard, branch and SRAM handshake into freeze/flush/bubble
// controls, with a memory-wait watchdog and saturating stall/flush counters.
module pipeline_stall_ctrl
    import arm_pipe_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_hazard_detected,
    input  logic             i_branch_taken,
    input  logic             i_mem_req,
    input  logic             i_mem_ready,
    input  logic             i_cnt_clr,
    output logic             o_freeze_front,
    output logic             o_freeze_back,
    output logic             o_flush_if,
    output logic             o_bubble_ex,
    output logic             o_mem_error,
    output logic [CNT_W-1:0] o_stall_cycles,
    output logic [CNT_W-1:0] o_flush_count
);

    localparam int unsigned      TMO_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

    pipe_state_e      r_state;
    logic [TMO_W-1:0] r_tmo;

    logic w_freeze_front;
    logic w_freeze_back;
    logic w_flush_if;
    logic w_bubble_ex;
    logic w_mem_error;
    logic w_mem_stall;

    assign w_mem_stall = i_mem_req && !i_mem_ready;

    // r_tmo holds the number of wait cycles already spent, including the entry cycle in RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_tmo   <= '0;
        end else begin
            unique case (r_state)
                ST_RUN: begin
                    if (w_mem_stall) begin
                        r_tmo   <= TMO_ONE;
                        r_state <= (MEM_TIMEOUT == 1) ? ST_ERROR : ST_MEM_WAIT;
                    end
                end
                ST_MEM_WAIT: begin
                    if (i_mem_ready) begin
                        r_state <= ST_RUN;
                        r_tmo   <= '0;
                    end else if (r_tmo == TMO_LAST) begin
                        r_state <= ST_ERROR;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                ST_ERROR: begin
                    r_state <= ST_ERROR;
                end
                default: begin
                    r_state <= ST_RUN;
                    r_tmo   <= '0;
                end
            endcase
        end
    end

    // Outputs are zero-latency; reset forces them low regardless of inputs.
    always_comb begin
        w_freeze_front = 1'b0;
        w_freeze_back  = 1'b0;
        w_flush_if     = 1'b0;
        w_bubble_ex    = 1'b0;
        w_mem_error    = 1'b0;
        if (rst_n) begin
            unique case (r_state)
                ST_RUN: begin
                    if (w_mem_stall) begin
                        w_freeze_front = 1'b1;
                        w_freeze_back  = 1'b1;
                    end else if (i_branch_taken) begin
                        w_flush_if  = 1'b1;
                        w_bubble_ex = 1'b1;
                    end else if (i_hazard_detected) begin
                        w_freeze_front = 1'b1;
                        w_bubble_ex    = 1'b1;
                    end
                end
                ST_MEM_WAIT: begin
                    w_freeze_front = !i_mem_ready;
                    w_freeze_back  = !i_mem_ready;
                end
                ST_ERROR: begin
                    w_freeze_front = 1'b1;
                    w_freeze_back  = 1'b1;
                    w_mem_error    = 1'b1;
                end
                default: begin
                    w_freeze_front = 1'b0;
                end
            endcase
        end
    end

    assign o_freeze_front = w_freeze_front;
    assign o_freeze_back  = w_freeze_back;
    assign o_flush_if     = w_flush_if;
    assign o_bubble_ex    = w_bubble_ex;
    assign o_mem_error    = w_mem_error;

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (i_cnt_clr),
        .i_inc (w_freeze_front),
        .o_q   (o_stall_cycles)
    );

    sat_counter #(
        .W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (i_cnt_clr),
        .i_inc (w_flush_if),
        .o_q   (o_flush_count)
    );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl with MEM_TIMEOUT=4 and CNT_W=3.
module tb_pipeline_stall_ctrl;

    localparam int unsigned MEM_TIMEOUT = 4;
    localparam int unsigned CNT_W       = 3;

    logic             clk;
    logic             rst_n;
    logic             hazard;
    logic             branch;
    logic             mem_req;
    logic             mem_ready;
    logic             cnt_clr;
    logic             freeze_front;
    logic             freeze_back;
    logic             flush_if;
    logic             bubble_ex;
    logic             mem_error;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;
    logic [4:0]       ctl;

    int n_chk;
    int n_fail;

    pipeline_stall_ctrl #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_hazard_detected (hazard),
        .i_branch_taken    (branch),
        .i_mem_req         (mem_req),
        .i_mem_ready       (mem_ready),
        .i_cnt_clr         (cnt_clr),
        .o_freeze_front    (freeze_front),
        .o_freeze_back     (freeze_back),
        .o_flush_if        (flush_if),
        .o_bubble_ex       (bubble_ex),
        .o_mem_error       (mem_error),
        .o_stall_cycles    (stall_cycles),
        .o_flush_count     (flush_count)
    );

    // {freeze_front, freeze_back, flush_if, bubble_ex, mem_error}
    assign ctl = {freeze_front, freeze_back, flush_if, bubble_ex, mem_error};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        hazard    = 1'b0;
        branch    = 1'b0;
        mem_req   = 1'b0;
        mem_ready = 1'b0;
        cnt_clr   = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n   = 1'b0;
        mem_req = 1'b1;
        hazard  = 1'b1;
        #1;
        n_chk++;
        if (ctl !== 5'b00000) begin
            $display("FAIL reset_ctl: got %b want 00000", ctl);
            n_fail++;
        end
        n_chk++;
        if (stall_cycles !== 3'd0 || flush_count !== 3'd0) begin
            $display("FAIL reset_cnt: got %0d/%0d want 0/0", stall_cycles, flush_count);
            n_fail++;
        end
        tick();
        n_chk++;
        if (ctl !== 5'b00000 || stall_cycles !== 3'd0) begin
            $display("FAIL reset_hold: got ctl %b stall %0d want 00000 0", ctl, stall_cycles);
            n_fail++;
        end
        clear_inputs();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_hazard();
        do_reset();
        hazard = 1'b1;
        #1;
        n_chk++;
        if (ctl !== 5'b10010) begin
            $display("FAIL hazard_c1: got %b want 10010", ctl);
            n_fail++;
        end
        tick();
        n_chk++;
        if (ctl !== 5'b10010) begin
            $display("FAIL hazard_c2: got %b want 10010", ctl);
            n_fail++;
        end
        tick();
        hazard = 1'b0;
        #1;
        n_chk++;
        if (ctl !== 5'b00000) begin
            $display("FAIL hazard_idle: got %b want 00000", ctl);
            n_fail++;
        end
        n_chk++;
        if (stall_cycles !== 3'd2 || flush_count !== 3'd0) begin
            $display("FAIL hazard_cnt: got %0d/%0d want 2/0", stall_cycles, flush_count);
            n_fail++;
        end
    endtask

    task automatic test_branch();
        do_reset();
        branch = 1'b1;
        hazard = 1'b1;
        #1;
        n_chk++;
        if (ctl !== 5'b00110) begin
            $display("FAIL branch_ctl: got %b want 00110", ctl);
            n_fail++;
        end
        tick();
        clear_inputs();
        #1;
        n_chk++;
        if (flush_count !== 3'd1 || stall_cycles !== 3'd0) begin
            $display("FAIL branch_cnt: got flush %0d stall %0d want 1 0", flush_count,
                     stall_cycles);
            n_fail++;
        end
    endtask

    task automatic test_mem_wait();
        do_reset();
        mem_req   = 1'b1;
        mem_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if (ctl !== 5'b11000) begin
                $display("FAIL mem_wait_c%0d: got %b want 11000", i + 1, ctl);
                n_fail++;
            end
            if (i < 2) tick();
        end
        tick();
        mem_ready = 1'b1;
        // Branch/hazard must be ignored while still in the wait state.
        hazard = 1'b1;
        #1;
        n_chk++;
        if (ctl !== 5'b00000) begin
            $display("FAIL mem_ready_cycle: got %b want 00000", ctl);
            n_fail++;
        end
        tick();
        clear_inputs();
        hazard = 1'b1;
        #1;
        n_chk++;
        if (ctl !== 5'b10010) begin
            $display("FAIL mem_back_run: got %b want 10010", ctl);
            n_fail++;
        end
        n_chk++;
        if (stall_cycles !== 3'd3) begin
            $display("FAIL mem_stall_cnt: got %0d want 3", stall_cycles);
            n_fail++;
        end
        hazard = 1'b0;
        mem_req   = 1'b1;
        mem_ready = 1'b1;
        #1;
        n_chk++;
        if (ctl !== 5'b00000) begin
            $display("FAIL mem_same_cycle: got %b want 00000", ctl);
            n_fail++;
        end
        clear_inputs();
    endtask

    task automatic test_timeout();
        do_reset();
        mem_req   = 1'b1;
        mem_ready = 1'b0;
        #1;
        for (int i = 1; i <= 4; i++) begin
            n_chk++;
            if (ctl !== 5'b11000) begin
                $display("FAIL tmo_wait%0d: got %b want 11000", i, ctl);
                n_fail++;
            end
            tick();
        end
        n_chk++;
        if (ctl !== 5'b11001) begin
            $display("FAIL tmo_error: got %b want 11001", ctl);
            n_fail++;
        end
        mem_req   = 1'b0;
        mem_ready = 1'b1;
        tick();
        tick();
        n_chk++;
        if (ctl !== 5'b11001) begin
            $display("FAIL tmo_sticky: got %b want 11001", ctl);
            n_fail++;
        end
        n_chk++;
        if (stall_cycles !== 3'd6) begin
            $display("FAIL tmo_cnt: got %0d want 6", stall_cycles);
            n_fail++;
        end
        tick();
        tick();
        n_chk++;
        if (stall_cycles !== 3'd7) begin
            $display("FAIL tmo_sat: got %0d want 7", stall_cycles);
            n_fail++;
        end
    endtask

    task automatic test_saturate();
        do_reset();
        hazard = 1'b1;
        repeat (10) tick();
        n_chk++;
        if (stall_cycles !== 3'd7) begin
            $display("FAIL sat_stall: got %0d want 7", stall_cycles);
            n_fail++;
        end
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        hazard  = 1'b0;
        #1;
        n_chk++;
        if (stall_cycles !== 3'd0) begin
            $display("FAIL sat_clr_wins: got %0d want 0", stall_cycles);
            n_fail++;
        end
        tick();
        n_chk++;
        if (stall_cycles !== 3'd0) begin
            $display("FAIL sat_clr_hold: got %0d want 0", stall_cycles);
            n_fail++;
        end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        mem_req   = 1'b1;
        mem_ready = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (ctl !== 5'b00000 || stall_cycles !== 3'd0) begin
            $display("FAIL rst_mid_wait: got ctl %b stall %0d want 00000 0", ctl, stall_cycles);
            n_fail++;
        end
        tick();
        rst_n     = 1'b1;
        mem_ready = 1'b1;
        #1;
        n_chk++;
        if (ctl !== 5'b00000) begin
            $display("FAIL rst_req_ready: got %b want 00000", ctl);
            n_fail++;
        end
        tick();
        clear_inputs();
        hazard = 1'b1;
        #1;
        n_chk++;
        if (ctl !== 5'b10010 || stall_cycles !== 3'd0) begin
            $display("FAIL rst_run_after: got ctl %b stall %0d want 10010 0", ctl, stall_cycles);
            n_fail++;
        end
        clear_inputs();
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        clear_inputs();
        rst_n = 1'b0;
        test_reset();
        test_hazard();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_saturate();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
